// File: rtl/conv3x3_stream_mc_if.sv
// rtl/conv3x3_stream_mc_if.sv - pixel/coef/result handshake bundle for conv3x3_stream_mc
interface conv3x3_stream_mc_if #(
   parameter int DATA_WIDTH = 8,
   parameter int COEF_WIDTH = 8,
   parameter int NUM_OCH    = 2
);
   localparam int AW  = $clog2(NUM_OCH * 9);
   localparam int CHW = (NUM_OCH > 1) ? $clog2(NUM_OCH) : 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] pixel_in;
   logic                  coef_we;
   logic [AW-1:0]         coef_addr;
   logic [COEF_WIDTH-1:0] coef_wdata;
   logic                  relu_en;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CHW-1:0]        out_ch;
   logic                  out_last;

   modport slave (
      input  in_valid, pixel_in, coef_we, coef_addr, coef_wdata, relu_en, out_ready,
      output in_ready, out_valid, out_data, out_ch, out_last
   );

   modport master (
      output in_valid, pixel_in, coef_we, coef_addr, coef_wdata, relu_en, out_ready,
      input  in_ready, out_valid, out_data, out_ch, out_last
   );
endinterface

// File: rtl/conv3x3_stream_mc.sv
// rtl/conv3x3_stream_mc.sv - streaming 3x3 convolution, NUM_OCH channels time-multiplexed per window
module conv3x3_stream_mc #(
   parameter int DATA_WIDTH = 8,
   parameter int COEF_WIDTH = 8,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28,
   parameter int NUM_OCH    = 2,
   parameter int SHIFT      = 0
) (
   input logic               clk,
   input logic               rst_n,
   conv3x3_stream_mc_if.slave bus
);
   localparam int NCOEF  = NUM_OCH * 9;
   localparam int AW     = $clog2(NCOEF);
   localparam int CHW    = (NUM_OCH > 1) ? $clog2(NUM_OCH) : 1;
   localparam int CLW    = $clog2(IMG_WIDTH);
   localparam int RWW    = $clog2(IMG_HEIGHT);
   localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + 5;
   localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;

   localparam logic [0:0] S_ACCEPT = 1'b0;
   localparam logic [0:0] S_MAC    = 1'b1;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   logic [0:0]                   state_q, state_d;
   logic [CLW-1:0]               col_q, col_d;
   logic [RWW-1:0]               row_q, row_d;
   logic [CHW-1:0]               ch_q, ch_d;
   logic                         last_win_q, last_win_d;
   logic                         out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
   logic [CHW-1:0]               out_ch_q, out_ch_d;
   logic                         out_last_q, out_last_d;
   logic signed [COEF_WIDTH-1:0] coef_q [NCOEF];
   logic signed [COEF_WIDTH-1:0] coef_d [NCOEF];
   // window flattened as ky*3+kx; kx=0 is the oldest column
   logic [DATA_WIDTH-1:0]        win_q [9];
   logic [DATA_WIDTH-1:0]        win_d [9];
   logic [DATA_WIDTH-1:0]        lb0_mem [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]        lb1_mem [IMG_WIDTH];

   logic                     accept, out_free, col_end, row_end, ch_end;
   logic [AW-1:0]            cidx;
   logic signed [PROD_W-1:0] pix_ext, cf_ext, prod;
   logic signed [ACC_W-1:0]  acc, shifted, result;

   assign bus.in_ready  = rst_n && (state_q == S_ACCEPT);
   assign accept        = bus.in_valid && bus.in_ready;
   assign out_free      = !out_valid_q || bus.out_ready;
   assign col_end       = (col_q == CLW'(IMG_WIDTH - 1));
   assign row_end       = (row_q == RWW'(IMG_HEIGHT - 1));
   assign ch_end        = (ch_q == CHW'(NUM_OCH - 1));
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_last  = out_last_q;

   always_comb begin
      acc = '0; prod = '0; pix_ext = '0; cf_ext = '0; cidx = '0;
      for (int k = 0; k < 9; k++) begin
         cidx    = AW'(int'(ch_q) * 9 + k);
         pix_ext = PROD_W'(win_q[k]);
         cf_ext  = PROD_W'(coef_q[cidx]);
         prod    = pix_ext * cf_ext;
         acc     = acc + ACC_W'(prod);
      end
      shifted = acc >>> SHIFT;
      result  = shifted;
      if (bus.relu_en && shifted[ACC_W-1]) result = '0;
      if (result > SAT_MAX)      result = SAT_MAX;
      else if (result < SAT_MIN) result = SAT_MIN;
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      ch_d        = ch_q;
      last_win_d  = last_win_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_last_d  = out_last_q;
      coef_d      = coef_q;
      win_d       = win_q;
      if (bus.coef_we && (bus.coef_addr < AW'(NCOEF))) coef_d[bus.coef_addr] = bus.coef_wdata;
      if (accept) begin
         col_d = col_end ? '0 : col_q + CLW'(1);
         if (col_end) row_d = row_end ? '0 : row_q + RWW'(1);
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
         end
         win_d[2] = lb1_mem[col_q];
         win_d[5] = lb0_mem[col_q];
         win_d[8] = bus.pixel_in;
         if (row_q >= RWW'(2) && col_q >= CLW'(2)) begin
            state_d    = S_MAC;
            ch_d       = '0;
            last_win_d = row_end && col_end;
         end
      end
      if (state_q == S_MAC && out_free) begin
         out_valid_d = 1'b1;
         out_data_d  = result[DATA_WIDTH-1:0];
         out_ch_d    = ch_q;
         out_last_d  = last_win_q && ch_end;
         if (ch_end) state_d = S_ACCEPT;
         else        ch_d    = ch_q + CHW'(1);
      end
   end

   // line buffers and window hold only pixel history, so they skip reset
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_mem[col_q] <= lb0_mem[col_q];
         lb0_mem[col_q] <= bus.pixel_in;
      end
      win_q <= win_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_ACCEPT;
         col_q       <= '0;
         row_q       <= '0;
         ch_q        <= '0;
         last_win_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_last_q  <= 1'b0;
         coef_q      <= '{default: '0};
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         ch_q        <= ch_d;
         last_win_q  <= last_win_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_last_q  <= out_last_d;
         coef_q      <= coef_d;
      end
   end
endmodule

// File: tb/tb_conv3x3_stream_mc.sv
// tb/tb_conv3x3_stream_mc.sv - randomized self-checking bench, SHIFT=0 and SHIFT=3 instances in lockstep
module tb_conv3x3_stream_mc;
   localparam int W = 5;
   localparam int H = 5;
   localparam int NOCH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, in_valid, coef_we, relu_en, out_ready;
   logic [7:0] pixel_in, coef_wdata;
   logic [4:0] coef_addr;

   conv3x3_stream_mc_if #(.DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_OCH(NOCH)) if0 ();
   conv3x3_stream_mc_if #(.DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_OCH(NOCH)) if1 ();

   assign if0.in_valid = in_valid;   assign if1.in_valid = in_valid;
   assign if0.pixel_in = pixel_in;   assign if1.pixel_in = pixel_in;
   assign if0.coef_we = coef_we;     assign if1.coef_we = coef_we;
   assign if0.coef_addr = coef_addr; assign if1.coef_addr = coef_addr;
   assign if0.coef_wdata = coef_wdata; assign if1.coef_wdata = coef_wdata;
   assign if0.relu_en = relu_en;     assign if1.relu_en = relu_en;
   assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

   conv3x3_stream_mc #(.DATA_WIDTH(8), .COEF_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                       .NUM_OCH(NOCH), .SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   conv3x3_stream_mc #(.DATA_WIDTH(8), .COEF_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                       .NUM_OCH(NOCH), .SHIFT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   int checks = 0;
   int errors = 0;
   int img [H][W];
   int cf [NOCH*9];
   bit relu;
   logic [9:0] exp0[$], exp1[$], got0[$], got1[$];

   always @(negedge clk) begin
      if (if0.out_valid && out_ready) got0.push_back({if0.out_last, if0.out_ch, if0.out_data});
      if (if1.out_valid && out_ready) got1.push_back({if1.out_last, if1.out_ch, if1.out_data});
   end

   // reference: direct image arithmetic for SHIFT=0 (exp0) and SHIFT=3 (exp1)
   task automatic model_frame();
      for (int r = 2; r < H; r++)
         for (int c = 2; c < W; c++)
            for (int ch = 0; ch < NOCH; ch++) begin
               int acc;
               acc = 0;
               for (int ky = 0; ky < 3; ky++)
                  for (int kx = 0; kx < 3; kx++)
                     acc += img[r-2+ky][c-2+kx] * cf[ch*9 + ky*3 + kx];
               for (int s = 0; s < 2; s++) begin
                  int v;
                  logic [9:0] e;
                  v = (s == 0) ? acc : (acc >>> 3);
                  if (relu && v < 0) v = 0;
                  if (v > 127) v = 127;
                  if (v < -128) v = -128;
                  e = {(r == H-1 && c == W-1 && ch == NOCH-1), ch[0], v[7:0]};
                  if (s == 0) exp0.push_back(e); else exp1.push_back(e);
               end
            end
   endtask

   task automatic clear_q();
      exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
   endtask

   task automatic set_ramp();
      for (int i = 0; i < W*H; i++) img[i/W][i%W] = i;
   endtask

   task automatic set_const(input int v);
      for (int i = 0; i < W*H; i++) img[i/W][i%W] = v;
   endtask

   task automatic set_basic_coefs();
      for (int k = 0; k < NOCH*9; k++) cf[k] = (k >= 9) ? 1 : 0;
      cf[4] = 1;
   endtask

   task automatic load_coefs();
      for (int k = 0; k < NOCH*9; k++) begin
         coef_we = 1'b1; coef_addr = 5'(k); coef_wdata = 8'(cf[k]);
         @(posedge clk); #1;
      end
      coef_we = 1'b0;
      relu_en = relu;
   endtask

   task automatic send_pixel(input int p);
      int n;
      n = 0;
      in_valid = 1'b1;
      pixel_in = 8'(p);
      @(negedge clk);
      while (!if0.in_ready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout: in_ready=%b required 1", if0.in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic feed_frame(input int gap_max);
      for (int i = 0; i < W*H; i++) begin
         repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
         send_pixel(img[i/W][i%W]);
      end
   endtask

   task automatic wait_drain(input int n);
      int k;
      k = 0;
      while ((got0.size() < n || got1.size() < n) && k < 3000) begin @(posedge clk); k++; end
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; pixel_in = '0; coef_we = 1'b0; coef_addr = '0;
      coef_wdata = '0; relu_en = 1'b0; out_ready = 1'b1; relu = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 2;
      if (if0.in_ready !== 1'b0 || if1.in_ready !== 1'b0)
         begin errors++; $display("FAIL reset_in_ready: got %b/%b required 0", if0.in_ready, if1.in_ready); end
      if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0)
         begin errors++; $display("FAIL reset_out_valid: got %b/%b required 0", if0.out_valid, if1.out_valid); end
      rst_n = 1'b1;
      @(negedge clk);
      checks += 2;
      if (if0.in_ready !== 1'b1)
         begin errors++; $display("FAIL post_reset_in_ready: got %b required 1", if0.in_ready); end
      if ({if0.out_valid, if0.out_data, if0.out_ch, if0.out_last} !== 11'd0)
         begin errors++; $display("FAIL post_reset_outputs: got %b required 0", {if0.out_valid, if0.out_data, if0.out_ch, if0.out_last}); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      clear_q(); set_ramp(); set_basic_coefs(); relu = 1'b0; load_coefs(); out_ready = 1'b1;
      model_frame();
      for (int i = 0; i <= 12; i++) send_pixel(i);
      checks++;
      if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b0)
         begin errors++; $display("FAIL basic_accept_edge: valid=%b ready=%b required 0 0", if0.out_valid, if0.in_ready); end
      @(posedge clk); #1;
      checks++;
      if ({if0.out_valid, if0.out_ch, if0.out_data} !== {1'b1, 1'b0, 8'd6})
         begin errors++; $display("FAIL basic_latency: got %h required %h", {if0.out_valid, if0.out_ch, if0.out_data}, {1'b1, 1'b0, 8'd6}); end
      for (int i = 13; i < W*H; i++) send_pixel(i);
      wait_drain(18);
      checks += 2;
      if (got0.size() != 18 || got1.size() != 18)
         begin errors++; $display("FAIL basic_count: got %0d/%0d required 18", got0.size(), got1.size()); end
      if (got0.size() == 18 && (got0[1] !== {1'b0, 1'b1, 8'd54} || got0[17] !== {1'b1, 1'b1, 8'd127}))
         begin errors++; $display("FAIL basic_const: got %h %h required %h %h", got0[1], got0[17], {1'b0, 1'b1, 8'd54}, {1'b1, 1'b1, 8'd127}); end
      for (int i = 0; i < exp0.size(); i++) begin
         checks += 2;
         if (i >= got0.size() || got0[i] !== exp0[i])
            begin errors++; $display("FAIL basic_s0[%0d]: got %h required %h", i, (i < got0.size()) ? got0[i] : 10'h3ff, exp0[i]); end
         if (i >= got1.size() || got1[i] !== exp1[i])
            begin errors++; $display("FAIL basic_s3[%0d]: got %h required %h", i, (i < got1.size()) ? got1[i] : 10'h3ff, exp1[i]); end
      end
   endtask

   task automatic test_saturation();
      for (int rl = 0; rl < 2; rl++) begin
         clear_q(); set_const(255);
         for (int k = 0; k < NOCH*9; k++) cf[k] = (k < 9) ? 1 : -1;
         relu = rl[0]; load_coefs();
         model_frame(); feed_frame(1); wait_drain(exp0.size());
         checks++;
         if (got0.size() < 2 || got0[1] !== {1'b0, 1'b1, (rl == 0) ? 8'h80 : 8'h00} || got0[0] !== {1'b0, 1'b0, 8'd127})
            begin errors++; $display("FAIL sat_const relu=%0d: got %h %h", rl, (got0.size() > 0) ? got0[0] : 10'h3ff, (got0.size() > 1) ? got0[1] : 10'h3ff); end
         for (int i = 0; i < exp0.size(); i++) begin
            checks += 2;
            if (i >= got0.size() || got0[i] !== exp0[i])
               begin errors++; $display("FAIL sat_s0[%0d] relu=%0d: got %h required %h", i, rl, (i < got0.size()) ? got0[i] : 10'h3ff, exp0[i]); end
            if (i >= got1.size() || got1[i] !== exp1[i])
               begin errors++; $display("FAIL sat_s3[%0d] relu=%0d: got %h required %h", i, rl, (i < got1.size()) ? got1[i] : 10'h3ff, exp1[i]); end
         end
      end
   endtask

   task automatic test_shift();
      clear_q(); set_const(16);
      for (int k = 0; k < NOCH*9; k++) cf[k] = 1;
      relu = 1'b0; load_coefs();
      model_frame(); feed_frame(2); wait_drain(18);
      checks++;
      if (got1.size() != 18)
         begin errors++; $display("FAIL shift_count: got %0d required 18", got1.size()); end
      for (int i = 0; i < got1.size(); i++) begin
         checks += 2;
         if (got1[i][7:0] !== 8'd18)
            begin errors++; $display("FAIL shift3_value[%0d]: got %0d required 18", i, got1[i][7:0]); end
         if (i >= got0.size() || got0[i] !== exp0[i])
            begin errors++; $display("FAIL shift0[%0d]: got %h required %h", i, (i < got0.size()) ? got0[i] : 10'h3ff, exp0[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] d;
      logic       c;
      clear_q(); set_ramp(); set_basic_coefs(); relu = 1'b0; load_coefs();
      model_frame();
      out_ready = 1'b0;
      fork
         feed_frame(2);
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (!if0.out_valid && n < 1000) begin @(negedge clk); n++; end
            checks++;
            if (!if0.out_valid) begin errors++; $display("FAIL bp_first_valid: got 0 required 1"); end
            d = if0.out_data; c = if0.out_ch[0];
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               checks++;
               if (if0.out_valid !== 1'b1 || if0.out_data !== d || if0.out_ch[0] !== c || if0.in_ready !== 1'b0)
                  begin errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%b rdy=%b required 1 %h %b 0", k, if0.out_valid, if0.out_data, if0.out_ch, if0.in_ready, d, c); end
            end
            @(posedge clk); #1;
            repeat (60) begin out_ready = 1'($urandom_range(0, 1)); @(posedge clk); #1; end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      wait_drain(18);
      for (int i = 0; i < exp0.size(); i++) begin
         checks += 2;
         if (i >= got0.size() || got0[i] !== exp0[i])
            begin errors++; $display("FAIL bp_s0[%0d]: got %h required %h", i, (i < got0.size()) ? got0[i] : 10'h3ff, exp0[i]); end
         if (i >= got1.size() || got1[i] !== exp1[i])
            begin errors++; $display("FAIL bp_s3[%0d]: got %h required %h", i, (i < got1.size()) ? got1[i] : 10'h3ff, exp1[i]); end
      end
      checks++;
      if (got0.size() != 18) begin errors++; $display("FAIL bp_count: got %0d required 18", got0.size()); end
   endtask

   task automatic test_back_to_back();
      int lasts;
      clear_q(); set_ramp(); set_basic_coefs(); relu = 1'b0; load_coefs(); out_ready = 1'b1;
      model_frame(); model_frame();
      feed_frame(0);
      for (int i = 0; i <= 12; i++) send_pixel(i);
      @(posedge clk); #1;
      checks++;
      if ({if0.out_valid, if0.out_ch, if0.out_data} !== {1'b1, 1'b0, 8'd6})
         begin errors++; $display("FAIL b2b_frame2_first: got %h required %h", {if0.out_valid, if0.out_ch, if0.out_data}, {1'b1, 1'b0, 8'd6}); end
      for (int i = 13; i < W*H; i++) send_pixel(i);
      wait_drain(36);
      lasts = 0;
      for (int i = 0; i < got0.size(); i++) lasts += int'(got0[i][9]);
      checks += 2;
      if (lasts != 2) begin errors++; $display("FAIL b2b_last_count: got %0d required 2", lasts); end
      if (got0.size() != 36) begin errors++; $display("FAIL b2b_count: got %0d required 36", got0.size()); end
      for (int i = 0; i < exp0.size(); i++) begin
         checks += 2;
         if (i >= got0.size() || got0[i] !== exp0[i])
            begin errors++; $display("FAIL b2b_s0[%0d]: got %h required %h", i, (i < got0.size()) ? got0[i] : 10'h3ff, exp0[i]); end
         if (i >= got1.size() || got1[i] !== exp1[i])
            begin errors++; $display("FAIL b2b_s3[%0d]: got %h required %h", i, (i < got1.size()) ? got1[i] : 10'h3ff, exp1[i]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_q(); set_ramp(); set_basic_coefs(); relu = 1'b0; load_coefs(); out_ready = 1'b1;
      for (int i = 0; i <= 14; i++) send_pixel(i);
      @(posedge clk); #2;
      checks++;
      if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b required 1", if0.out_valid); end
      rst_n = 1'b0;
      #1;
      checks += 2;
      if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0)
         begin errors++; $display("FAIL rstmid_async_valid: got %b/%b required 0", if0.out_valid, if1.out_valid); end
      if (if0.in_ready !== 1'b0 || if0.out_data !== 8'd0)
         begin errors++; $display("FAIL rstmid_async_state: ready=%b data=%h required 0 00", if0.in_ready, if0.out_data); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < NOCH*9; k++) cf[k] = 0;
      for (int pass = 0; pass < 2; pass++) begin
         clear_q();
         if (pass == 1) begin set_basic_coefs(); load_coefs(); end
         model_frame(); feed_frame(1); wait_drain(18);
         checks++;
         if (got0.size() != 18 || got1.size() != 18)
            begin errors++; $display("FAIL rstmid_count pass%0d: got %0d/%0d required 18", pass, got0.size(), got1.size()); end
         for (int i = 0; i < exp0.size(); i++) begin
            checks += 2;
            if (i >= got0.size() || got0[i] !== exp0[i])
               begin errors++; $display("FAIL rstmid_s0[%0d] pass%0d: got %h required %h", i, pass, (i < got0.size()) ? got0[i] : 10'h3ff, exp0[i]); end
            if (i >= got1.size() || got1[i] !== exp1[i])
               begin errors++; $display("FAIL rstmid_s3[%0d] pass%0d: got %h required %h", i, pass, (i < got1.size()) ? got1[i] : 10'h3ff, exp1[i]); end
         end
      end
   endtask

   task automatic test_random();
      bit feeding;
      for (int it = 0; it < 4; it++) begin
         clear_q();
         for (int k = 0; k < NOCH*9; k++) cf[k] = int'($urandom_range(0, 255)) - 128;
         for (int i = 0; i < W*H; i++) img[i/W][i%W] = int'($urandom_range(0, 255));
         relu = 1'($urandom_range(0, 1));
         load_coefs();
         model_frame();
         feeding = 1'b1;
         fork
            begin feed_frame(2); feeding = 1'b0; end
            while (feeding) begin out_ready = ($urandom_range(0, 3) != 0); @(posedge clk); #1; end
         join
         out_ready = 1'b1;
         wait_drain(18);
         checks++;
         if (got0.size() != 18 || got1.size() != 18)
            begin errors++; $display("FAIL rand_count it%0d: got %0d/%0d required 18", it, got0.size(), got1.size()); end
         for (int i = 0; i < exp0.size(); i++) begin
            checks += 2;
            if (i >= got0.size() || got0[i] !== exp0[i])
               begin errors++; $display("FAIL rand_s0[%0d] it%0d: got %h required %h", i, it, (i < got0.size()) ? got0[i] : 10'h3ff, exp0[i]); end
            if (i >= got1.size() || got1[i] !== exp1[i])
               begin errors++; $display("FAIL rand_s3[%0d] it%0d: got %h required %h", i, it, (i < got1.size()) ? got1[i] : 10'h3ff, exp1[i]); end
         end
      end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_shift();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
